// File: rtl/key_entry_unit.sv
// Keypad entry front-end for the calculator core: turns debounced key codes into
// two BCD-entered binary operands, an ALU opcode and a one-cycle finish pulse.
module key_entry_unit #(
    parameter int MAX_DIGITS = 3
) (
    input  logic       IN_clk,
    input  logic       IN_reset,
    input  logic       IN_key_valid,
    input  logic [3:0] IN_key_code,
    input  logic       IN_clear,
    output logic [7:0] OUT_SRCH,
    output logic [7:0] OUT_SRCL,
    output logic [7:0] OUT_DSTH,
    output logic [7:0] OUT_DSTL,
    output logic [3:0] OUT_ALU_OP,
    output logic       OUT_finish,
    output logic [1:0] OUT_state,
    output logic [1:0] OUT_flag
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OPA  = 2'd1,
        ST_OP   = 2'd2,
        ST_OPB  = 2'd3
    } state_t;

    localparam logic [1:0] MAX_FLAG    = 2'(MAX_DIGITS);
    localparam logic [1:0] FLAG_CLEAR  = 2'd3;
    localparam logic [3:0] KEY_EQUALS  = 4'hF;

    state_t      state_q, state_d;
    logic [15:0] a_q, a_d;
    logic [15:0] b_q, b_d;
    logic [3:0]  op_q, op_d;
    logic        finish_q, finish_d;
    logic [1:0]  flag_q, flag_d;
    logic        key_prev_q, key_prev_d;

    logic        key_accept;
    logic        is_digit;
    logic        is_oper;
    logic        is_equals;
    logic [15:0] acc_cur;
    logic [15:0] acc_val;
    logic [1:0]  acc_flag;

    assign key_accept = IN_key_valid && !key_prev_q;
    assign is_digit   = (IN_key_code <= 4'd9);
    assign is_oper    = (IN_key_code >= 4'hA) && (IN_key_code <= 4'hE);
    assign is_equals  = (IN_key_code == KEY_EQUALS);

    // Digit accumulation shared by both operands; only the selected one is written back.
    always_comb begin
        acc_cur  = (state_q == ST_OPB) ? b_q : a_q;
        acc_val  = acc_cur;
        acc_flag = flag_q;
        if (acc_cur == 16'd0) begin
            acc_val  = {12'd0, IN_key_code};
            acc_flag = 2'd1;
        end else if (flag_q < MAX_FLAG) begin
            acc_val  = (acc_cur << 3) + (acc_cur << 1) + {12'd0, IN_key_code};
            acc_flag = flag_q + 2'd1;
        end
    end

    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path can leave
        // one unassigned and infer a latch.
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        op_d       = op_q;
        flag_d     = flag_q;
        finish_d   = 1'b0;
        key_prev_d = IN_key_valid;

        if (IN_clear) begin
            state_d = ST_IDLE;
            a_d     = 16'd0;
            b_d     = 16'd0;
            op_d    = 4'd0;
            flag_d  = FLAG_CLEAR;
        end else if (key_accept) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (is_digit) begin
                        a_d     = {12'd0, IN_key_code};
                        b_d     = 16'd0;
                        op_d    = 4'd0;
                        flag_d  = 2'd1;
                        state_d = ST_OPA;
                    end
                end
                ST_OPA: begin
                    if (is_digit) begin
                        a_d    = acc_val;
                        flag_d = acc_flag;
                    end else if (is_oper) begin
                        op_d    = IN_key_code;
                        flag_d  = 2'd0;
                        state_d = ST_OP;
                    end
                end
                ST_OP: begin
                    if (is_digit) begin
                        b_d     = {12'd0, IN_key_code};
                        flag_d  = 2'd1;
                        state_d = ST_OPB;
                    end else if (is_oper) begin
                        op_d = IN_key_code;
                    end
                end
                ST_OPB: begin
                    if (is_digit) begin
                        b_d    = acc_val;
                        flag_d = acc_flag;
                    end else if (is_equals) begin
                        finish_d = 1'b1;
                        flag_d   = 2'd0;
                        state_d  = ST_IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge IN_clk or posedge IN_reset) begin
        if (IN_reset) begin
            state_q    <= ST_IDLE;
            a_q        <= 16'd0;
            b_q        <= 16'd0;
            op_q       <= 4'd0;
            finish_q   <= 1'b0;
            flag_q     <= FLAG_CLEAR;
            key_prev_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            op_q       <= op_d;
            finish_q   <= finish_d;
            flag_q     <= flag_d;
            key_prev_q <= key_prev_d;
        end
    end

    assign OUT_SRCH   = a_q[15:8];
    assign OUT_SRCL   = a_q[7:0];
    assign OUT_DSTH   = b_q[15:8];
    assign OUT_DSTL   = b_q[7:0];
    assign OUT_ALU_OP = op_q;
    assign OUT_finish = finish_q;
    assign OUT_state  = state_q;
    assign OUT_flag   = flag_q;

endmodule

// File: doc/key_entry_unit.md
Name: key_entry_unit

Overview:
- Upstream stage of the calculator core.
- Converts debounced 4x4 keypad codes into two binary operands, an ALU opcode, and an entry-progress state/digit count.
- Issues a one-cycle finish pulse on "=" so the core starts its two-pass 8-bit ALU sequence.
- Also drives the core's display-selection inputs (state, flag) while keys are being entered.

Parameters:
MAX_DIGITS, 3, maximum decimal digits per operand (legal 1..3; operand max 999).

Ports:
IN_clk  input  1  system clock, all logic on rising edge
IN_reset  input  1  asynchronous, active-high reset
IN_key_valid  input  1  key-present level from keypad scanner; one key accepted per rising edge
IN_key_code  input  4  0x0-0x9 digit, 0xA add, 0xB sub, 0xC and, 0xD or, 0xE cmp, 0xF equals
IN_clear  input  1  synchronous clear request (level, sampled each cycle)
OUT_SRCH  output  8  operand A bits [15:8]
OUT_SRCL  output  8  operand A bits [7:0]
OUT_DSTH  output  8  operand B bits [15:8]
OUT_DSTL  output  8  operand B bits [7:0]
OUT_ALU_OP  output  4  latched operator code (0xA-0xE), 0 when none
OUT_finish  output  1  one-cycle pulse: operands/op valid, start computation
OUT_state  output  2  0 idle, 1 entering A, 2 operator entered, 3 entering B
OUT_flag  output  2  digits entered in current operand; 3 in idle = "cleared" marker

Behaviour:
- Reset (async, any time): state=0, A=B=0, OUT_ALU_OP=0, OUT_finish=0, OUT_flag=3; edge-detect register=0.
- Key accept: accepted in cycle n when IN_key_valid=1 and it was 0 in cycle n-1. A held level produces exactly one key.
- Latency: all outputs are registered; an accepted key in cycle n updates the outputs in cycle n+1.
- IN_clear=1: same values as reset, applied on the next edge. It has priority over a simultaneous key.
- OUT_finish defaults to 0 every cycle unless set by "=".
- State IDLE(0):
  - Digit d: A=d, B=0, op=0, flag=1, go to 1.
  - Operator or "=": ignored; all outputs hold.
- State OPA(1):
  - Digit d: if flag<MAX_DIGITS then A=A*10+d, flag=flag+1; else ignored.
  - Leading zero: when A==0, A stays d and flag stays 1.
  - Operator 0xA-0xE: op latched, flag=0, go to 2.
  - "=": ignored.
- State OP(2):
  - Operator: replaces the latched op; stay in 2.
  - Digit d: B=d, flag=1, go to 3.
  - "=": ignored.
- State OPB(3):
  - Digit: same rules as OPA, applied to B.
  - Operator: ignored (no chaining).
  - "=": OUT_finish=1 for exactly one cycle, state=0, flag=0.
- After finish: A, B and op hold until the next digit in idle. The core samples low bytes on the finish cycle and high bytes later, so these values must stay stable.
- Arithmetic: x*10 computed as (x<<3)+(x<<1) in 16 bits. No overflow is possible within MAX_DIGITS<=3. High bytes are 0 for values <=255.
- OUT_flag=3 in idle only after reset/clear. This lets the core leave its result-hold state. A post-finish idle shows flag 0 so the result stays displayed.
- Undefined state encodings: none exist (2-bit, all used).

Test Plan:
- Reset, then keys 1,2,3,A,4,5,F as separate pulses -> SRC=0x007B, DST=0x002D, OUT_ALU_OP=0xA. OUT_finish is high exactly one cycle after F is accepted, with OUT_state=0 and OUT_flag=0.
- IN_key_valid held high 10 cycles with code 7 in idle -> A=7, flag=1, only one digit accepted.
- Keys 9,9,9,9 -> A=999, flag=3 (fourth digit ignored). Then B, 5, F -> SRC=0x03E7, DST=0x0005, op=0xB.
- Keys 0,0,5 -> A=5, flag=1. Keys A then C in state 2 -> op=0xC. A/C pressed in state 3, and F pressed in states 1/2, change nothing.
- IN_clear asserted simultaneously with a digit edge while in state 3 -> next cycle: state=0, flag=3, all operands 0, op=0, no finish.
- IN_reset pulsed asynchronously mid-cycle during entry -> outputs reach reset values immediately, without waiting for a clock edge. After release, keys 2,E,3,F -> op=0xE, finish pulse.
